// File: rtl/present_iter_ctrl.sv
// Iterative PRESENT-80 encryptor: one round, one key-schedule step per cycle,
// valid/ready handshake on the block input and the ciphertext output.
module present_iter_ctrl #(
    parameter int unsigned NROUNDS = 31
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [79:0] K,
    input  logic [63:0] M,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] C,
    output logic        busy,
    output logic [4:0]  rnd
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } fsm_t;

    localparam logic [4:0] LAST = 5'(NROUNDS);

    fsm_t        fsm_q, fsm_d;
    logic [63:0] state_q, state_d;
    logic [79:0] key_q, key_d;
    logic [4:0]  rnd_q, rnd_d;

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        unique case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            4'hF: y = 4'h2;
            default: y = 4'h0;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] sbox_layer(input logic [63:0] s);
        logic [63:0] o;
        o = '0;
        for (int n = 0; n < 16; n++) begin
            o[4*n +: 4] = sbox(s[4*n +: 4]);
        end
        return o;
    endfunction

    // Bit i moves to 16*i mod 63; bit 63 stays put.
    function automatic logic [63:0] p_layer(input logic [63:0] s);
        logic [63:0] o;
        logic [5:0]  idx;
        o = '0;
        for (int i = 0; i < 63; i++) begin
            idx      = 6'((i * 16) % 63);
            o[idx]   = s[i];
        end
        o[63] = s[63];
        return o;
    endfunction

    function automatic logic [63:0] key_addition(
        input logic [63:0] s,
        input logic [79:0] k
    );
        return s ^ k[79:16];
    endfunction

    function automatic logic [63:0] round_f(
        input logic [63:0] s,
        input logic [79:0] k
    );
        return p_layer(sbox_layer(key_addition(s, k)));
    endfunction

    function automatic logic [79:0] key_schedule(
        input logic [79:0] k,
        input logic [4:0]  r
    );
        logic [79:0] t;
        t          = {k[18:0], k[79:19]};
        t[79:76]   = sbox(t[79:76]);
        t[19:15]   = t[19:15] ^ r;
        return t;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d   = fsm_q;
        state_d = state_q;
        key_d   = key_q;
        rnd_d   = rnd_q;
        unique case (fsm_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = M;
                    key_d   = K;
                    rnd_d   = 5'd1;
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                // Round and key update both consume the pre-edge key.
                state_d = round_f(state_q, key_q);
                key_d   = key_schedule(key_q, rnd_q);
                if (rnd_q == LAST) begin
                    fsm_d = DONE;
                end else begin
                    rnd_d = rnd_q + 5'd1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    fsm_d = IDLE;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign in_ready  = (fsm_q == IDLE) && !rst;
    assign out_valid = (fsm_q == DONE);
    assign busy      = (fsm_q == RUN);
    assign rnd       = rnd_q;
    assign C         = key_addition(state_q, key_q);

endmodule

// File: tb/tb_present_iter_ctrl.sv
// Directed and streaming checks for the iterative PRESENT-80 controller.
module tb_present_iter_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [79:0] K;
    logic [63:0] M;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] C;
    logic        busy;
    logic [4:0]  rnd;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    localparam logic [63:0] C_ZERO = 64'h5579C1387B228445;
    localparam logic [63:0] C_ONES = 64'h3333DCD3213210D2;
    localparam logic [79:0] K_ONES = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] M_ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    present_iter_ctrl #(.NROUNDS(31)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .K         (K),
        .M         (M),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .C         (C),
        .busy      (busy),
        .rnd       (rnd)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [3:0] sb(input logic [3:0] x);
        logic [63:0] tab;
        tab = 64'h21748FE3DA09B65C;
        return tab[4*x +: 4];
    endfunction

    // Reference encryption: pLayer written as a gather (inverse map 4*j mod 63).
    function automatic logic [63:0] ref_enc(
        input logic [79:0] k0,
        input logic [63:0] m
    );
        logic [79:0] k;
        logic [63:0] s, t;
        k = k0;
        s = m;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ k[79:16];
            for (int n = 0; n < 16; n++) t[4*n +: 4] = sb(s[4*n +: 4]);
            for (int j = 0; j < 63; j++) s[j] = t[(4*j) % 63];
            s[63] = t[63];
            k = {k[18:0], k[79:19]};
            k[79:76] = sb(k[79:76]);
            k[19:15] = k[19:15] ^ 5'(r);
        end
        return s ^ k[79:16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        K = '0;
        M = '0;
        tick();
        tick();
        tests++;
        if (in_ready !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_flags: got ir=%b ov=%b busy=%b expected 0 0 0",
                     in_ready, out_valid, busy);
        end
        tests++;
        if (rnd !== 5'd0 || C !== 64'd0) begin
            fails++;
            $display("FAIL reset_regs: got rnd=%0d C=%h expected 0 0", rnd, C);
        end
        rst = 1'b0;
        tick();
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release: got in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_standard();
        int n;
        K = '0;
        M = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL std_accept: got busy=%b expected 1", busy);
        end
        wait_out(n);
        tests++;
        if (n != 31) begin
            fails++;
            $display("FAIL std_latency: got %0d cycles expected 31", n);
        end
        tests++;
        if (C !== C_ZERO) begin
            fails++;
            $display("FAIL std_cipher: got %h expected %h", C, C_ZERO);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL std_handshake: got ir=%b ov=%b expected 1 0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_all_ones();
        int bad;
        K = K_ONES;
        M = M_ONES;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        bad = 0;
        for (int i = 1; i <= 31; i++) begin
            if (busy !== 1'b1 || rnd !== 5'(i)) bad++;
            tick();
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL ones_busy_rnd: got %0d bad cycles expected 0", bad);
        end
        tests++;
        if (out_valid !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL ones_done: got ov=%b busy=%b expected 1 0",
                     out_valid, busy);
        end
        tests++;
        if (C !== C_ONES) begin
            fails++;
            $display("FAIL ones_cipher: got %h expected %h", C, C_ONES);
        end
    endtask

    task automatic test_backpressure();
        int bad;
        logic [63:0] c0;
        c0 = C_ONES;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (C !== c0 || out_valid !== 1'b1 || in_ready !== 1'b0) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        tests++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got ir=%b ov=%b expected 1 0",
                     in_ready, out_valid);
        end
        tests++;
        if (C !== c0) begin
            fails++;
            $display("FAIL bp_idle_keep: got %h expected %h", C, c0);
        end
    endtask

    task automatic test_isolation();
        int n;
        logic [79:0] k1;
        logic [63:0] m1, exp;
        k1 = 80'h0123_4567_89AB_CDEF_1357;
        m1 = 64'hFEDC_BA98_7654_3210;
        exp = ref_enc(k1, m1);
        K = k1;
        M = m1;
        in_valid = 1'b1;
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_valid = ~in_valid;
            K = {$urandom, $urandom, 16'($urandom)};
            M = {$urandom, $urandom};
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        wait_out(n);
        tests++;
        if (n != 21) begin
            fails++;
            $display("FAIL iso_latency: got %0d cycles expected 21", n);
        end
        tests++;
        if (C !== exp) begin
            fails++;
            $display("FAIL iso_cipher: got %h expected %h", C, exp);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        K = '0;
        M = '0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        n = 0;
        while (rnd !== 5'd15 && n < 40) begin
            tick();
            n++;
        end
        tests++;
        if (rnd !== 5'd15) begin
            fails++;
            $display("FAIL mid_reach15: got rnd=%0d expected 15", rnd);
        end
        rst = 1'b1;
        in_valid = 1'b1;
        tick();
        tests++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || rnd !== 5'd0
            || C !== 64'd0 || in_ready !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: got ov=%b busy=%b rnd=%0d C=%h ir=%b expected 0 0 0 0 0",
                     out_valid, busy, rnd, C, in_ready);
        end
        tick();
        tests++;
        if (busy !== 1'b0 || C !== 64'd0) begin
            fails++;
            $display("FAIL rst_beats_valid: got busy=%b C=%h expected 0 0",
                     busy, C);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        tick();
        K = K_ONES;
        M = M_ONES;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_out(n);
        tests++;
        if (n != 31 || C !== C_ONES) begin
            fails++;
            $display("FAIL mid_fresh: got n=%0d C=%h expected 31 %h",
                     n, C, C_ONES);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        int n, acc, prev;
        logic [79:0] ks;
        logic [63:0] ms, exp;
        in_valid = 1'b1;
        out_ready = 1'b1;
        prev = -1;
        for (int v = 0; v < 100; v++) begin
            ks = {$urandom, $urandom, 16'($urandom)};
            ms = {$urandom, $urandom};
            K = ks;
            M = ms;
            exp = ref_enc(ks, ms);
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready[%0d]: got %b expected 1", v, in_ready);
            end
            tick();
            acc = cyc;
            if (prev >= 0) begin
                tests++;
                if (acc - prev != 33) begin
                    fails++;
                    $display("FAIL b2b_spacing[%0d]: got %0d expected 33",
                             v, acc - prev);
                end
            end
            prev = acc;
            K = {$urandom, $urandom, 16'($urandom)};
            M = {$urandom, $urandom};
            wait_out(n);
            tests++;
            if (n != 31 || C !== exp) begin
                fails++;
                $display("FAIL b2b_cipher[%0d]: got n=%0d C=%h expected 31 %h",
                         v, n, C, exp);
            end
            tick();
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_standard();
        test_all_ones();
        test_backpressure();
        test_isolation();
        test_reset_mid();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/present_iter_ctrl.md
# present_iter_ctrl

Iterative PRESENT-80 encryption controller. Instead of a 31-stage unrolled pipeline, it time-multiplexes a single `round`, a single `key_schedule` and a single `key_addition` instance. It sequences one 64-bit block through 31 iterations with a valid/ready handshake on both sides. It is the area-optimised encryptor for the same datapath and produces the same ciphertext as a full PRESENT-80 encryption.

## Interface
Parameters:
- `NROUNDS`, default 31: number of round iterations. Must lie in 1..31, because the round counter is 5 bits.

Ports:
- `clk`  in  1: single clock; all state changes on the posedge.
- `rst`  in  1: synchronous, active-high reset.
- `in_valid`  in  1: a new block (`K`, `M`) is offered.
- `in_ready`  out  1: the controller can accept a block.
- `K`  in  80: key, sampled only on the input handshake.
- `M`  in  64: plaintext, sampled only on the input handshake.
- `out_valid`  out  1: `C` holds a finished ciphertext.
- `out_ready`  in  1: the consumer takes `C`.
- `C`  out  64: ciphertext, `key_addition(state_q, key_q)`.
- `busy`  out  1: high in RUN.
- `rnd`  out  5: current round counter, for debug.

## Operation
- Registers:
  - `state_q[63:0]`
  - `key_q[79:0]`
  - `rnd_q[4:0]`
  - FSM `fsm_q` with states IDLE, RUN, DONE.
- Datapath per RUN cycle:
  - `state_q <= round(state_q, key_q)`
  - `key_q <= key_schedule(key_q, rnd_q)`
  - The round and key schedule use the same pre-edge `key_q`.
- FSM transitions:
  - IDLE: if `in_valid`, load `state_q<=M`, `key_q<=K`, `rnd_q<=1`, go to RUN. Otherwise hold.
  - RUN: apply one iteration.
    - If `rnd_q==NROUNDS`, go to DONE and leave `rnd_q` unchanged.
    - Otherwise `rnd_q<=rnd_q+1`.
    - `in_valid` is ignored.
  - DONE: registers are frozen. If `out_ready`, go to IDLE. Otherwise hold.
- Output decode:
  - `in_ready = (fsm_q==IDLE) && !rst`
  - `out_valid = (fsm_q==DONE)`
  - `busy = (fsm_q==RUN)`
- `C` is combinational from the registers. In DONE it is stable and reflects the finished result. Outside DONE it changes every iteration and must be ignored.
- After the output handshake, `state_q`, `key_q` and `C` keep their last values in IDLE until the next accept.
- `rnd_q` never exceeds `NROUNDS` and never wraps. The counter value passed to `key_schedule` is `rnd_q` (1..NROUNDS).

## Timing
- Reset values:
  - `fsm_q=IDLE`, `state_q=0`, `key_q=0`, `rnd_q=0`.
  - `in_ready=0` while `rst` is high, 1 on the first cycle after release.
  - `out_valid=0`, `busy=0`, `rnd=0`, `C=key_addition(0,0)=0`.
- Latency:
  - Input handshake at edge t0; iterations occur at edges t1..tNROUNDS.
  - `out_valid` is high from the cycle after edge tNROUNDS, i.e. 31 cycles after the accept edge at default `NROUNDS`.
- Throughput: with `out_ready` held high, one block every 33 cycles (accept, 31 RUN, 1 DONE→IDLE).
  - The output handshake takes the DONE→IDLE edge.
  - The next accept is at the following edge, because `in_ready` is low in DONE.
- Back-pressure: DONE holds `out_valid` and `C` stable indefinitely while `out_ready=0`.
- Boundary cases:
  - `in_valid` during RUN or DONE: not accepted, and `K`/`M` changes have no effect.
  - `out_ready` high outside DONE: no effect.
  - `rst` asserted in any state, including mid-RUN or in DONE with `out_ready` high: next state is IDLE with reset values. The block being processed is discarded and no `out_valid` pulse occurs.
  - `rst` together with `in_valid` in IDLE: reset wins and nothing is loaded.

## Test plan
- Standard vector: reset, then `K=0`, `M=0` → `out_valid` rises exactly 31 cycles after the accept edge, with `C=64'h5579C1387B228445`.
- All-ones vector: `K=80'hFFFF_FFFF_FFFF_FFFF_FFFF`, `M=64'hFFFF_FFFF_FFFF_FFFF` → `C=64'h3333DCD3213210D2`. `busy` is high for 31 cycles and `rnd` steps 1..31.
- Back-pressure: hold `out_ready=0` for 50 cycles after `out_valid` → `C` and `out_valid` are constant and `in_ready=0` throughout. Releasing `out_ready` gives `in_ready=1` on the next cycle.
- Input isolation: change `K`/`M` and pulse `in_valid` during RUN → the result still matches the vector from the originally accepted `K`/`M`.
- Reset mid-operation: assert `rst` at `rnd=15` → the next cycle shows IDLE, `out_valid=0`, `C=0`, `rnd=0`. A fresh encryption afterwards is correct.
- Back-to-back stream: 100 random (`K`, `M`) with `in_valid` and `out_ready` held high → each `C` matches the golden PRESENT-80 model, at 33-cycle spacing.
